layer_controller_cfg_pio: RTL and testbench
===========================================

LAYER_CONTROLLER_CFG_PIO -- requirements
Module: layer_controller_cfg_pio

Interface
REQ-001 Parameters SHALL be:
- N_CH, default 4, number of output channels (1..30).
- DATA_W, default 8, bits per channel (1..32).
- RESET_VAL, default 0, reset value of every shadow and live channel.
REQ-002 Local ADDR_W SHALL be clog2(N_CH+2).
REQ-003 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data.
- out_port  out  N_CH*DATA_W  live channel values, channel i at bits [i*DATA_W +: DATA_W].
- out_valid  out  1  new live values pending for the layer.
- out_ack  in  1  layer has consumed the live values.
- irq  out  1  overflow interrupt.

Function
REQ-004 A write SHALL be chipselect=1 and write_n=0; it SHALL take effect at the next clk edge with zero wait states.
REQ-005 Register map SHALL be:
- 0 CTRL/STATUS: bit0 pending (RO, equals out_valid); bit1 overflow (sticky, write-1-to-clear); bit8 irq_en (RW).
- 1 COMMIT: write-only; reads return 0.
- 2+i SHADOW[i]: RW, DATA_W bits.
REQ-006 A SHADOW write SHALL store writedata[DATA_W-1:0] and ignore the upper bits; it SHALL NOT change out_port.
REQ-007 readdata SHALL be combinational from address, independent of chipselect, zero-extended to 32 bits; unmapped addresses SHALL read 0 and writes to them SHALL be ignored.
REQ-008 A write to COMMIT with writedata[0]=1 SHALL be a commit request; writedata[0]=0 SHALL have no effect.
REQ-009 A commit SHALL be accepted when out_valid=0, or when out_valid=1 and out_ack=1 in the same cycle.
REQ-010 On an accepted commit, all live channels SHALL load all shadows atomically, and out_valid SHALL be 1, both at the next edge.
REQ-011 A commit not accepted SHALL leave out_port and out_valid unchanged and SHALL set overflow at the next edge.
REQ-012 With out_valid=1, out_ack=1 and no accepted commit, out_valid SHALL clear at the next edge; out_ack SHALL be ignored while out_valid=0.
REQ-013 Handshake states SHALL be IDLE (out_valid=0) and PENDING (out_valid=1), with transitions:
- IDLE to PENDING on commit.
- PENDING to IDLE on ack without commit.
- PENDING to PENDING on ack with commit (new data loaded).
- PENDING to PENDING on commit without ack (rejected, overflow set).
REQ-014 Overflow set and a write-1-to-clear in the same cycle SHALL leave overflow=1 (set wins).
REQ-015 irq SHALL be overflow AND irq_en, registered-free (combinational from those flops).
REQ-016 out_port SHALL change only on an accepted commit or on reset.

Reset
REQ-017 When reset=1 at a clk edge:
- shadows and live channels SHALL be RESET_VAL.
- out_valid, overflow, irq_en and irq SHALL be 0.
- Reset SHALL override any simultaneous write or ack.
REQ-018 Reset asserted while PENDING SHALL return the block to IDLE and drop the pending update.

Structure
REQ-019 Package layer_controller_cfg_pio_pkg SHALL hold:
- register offsets CTRL=0, COMMIT=1, SHADOW_BASE=2.
- status bit positions (pending 0, overflow 1, irq_en 8).
- the handshake state enum.
REQ-020 Handshake and overflow logic SHALL be one sub-module, layer_controller_cfg_handshake; channel storage SHALL be generate loops in the top module.

Verification (N_CH=4, DATA_W=8)
REQ-021 Reset, then read all addresses -> every address reads 0; out_port=0; out_valid=0.
REQ-022 Write SHADOW0..3 = 0x11, 0x22, 0x33, 0x1FF -> out_port unchanged; SHADOW3 reads 0xFF. Then COMMIT=1 -> next cycle out_port=0xFF332211, out_valid=1, CTRL reads 0x1.
REQ-023 While PENDING, COMMIT=1 with out_ack=0 -> out_port unchanged, overflow=1. Write CTRL=0x100 -> irq=1. Write CTRL=0x102 -> overflow=0, irq=0.
REQ-024 While PENDING, COMMIT=1 in the same cycle as out_ack=1 -> new shadows loaded, out_valid stays 1, overflow stays 0. Then out_ack=1 alone -> out_valid=0 next cycle.
REQ-025 Reset pulse while PENDING with overflow=1 -> out_valid=0, overflow=0, out_port=RESET_VAL. Write to address 7 -> no state change.

Source files
------------

// File: rtl/layer_controller_cfg_pio_pkg.sv
// Shared constants and types for the layer controller configuration PIO block.
package layer_controller_cfg_pio_pkg;

    // Register word offsets
    localparam int CTRL_ADDR   = 0;
    localparam int COMMIT_ADDR = 1;
    localparam int SHADOW_BASE = 2;

    // CTRL/STATUS bit positions
    localparam int STAT_PENDING  = 0;
    localparam int STAT_OVERFLOW = 1;
    localparam int STAT_IRQ_EN   = 8;

    // COMMIT register: bit that requests a commit
    localparam int COMMIT_GO = 0;

    // Layer-side handshake state
    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_e;

    // Word address width needed for CTRL, COMMIT and one SHADOW per channel
    function automatic int addr_w(input int n_ch);
        return $clog2(n_ch + 2);
    endfunction

endpackage

// File: rtl/layer_controller_cfg_pio_if.sv
// Zero-wait-state register bus between a host master and the PIO block.
interface layer_controller_cfg_pio_if
    import layer_controller_cfg_pio_pkg::*;
#(
    parameter int N_CH = 4
);
    localparam int ADDR_W = addr_w(N_CH);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/layer_controller_cfg_handshake.sv
// Valid/ack handshake towards the layer plus the sticky overflow flag.
// A commit is accepted when nothing is pending or when the pending update
// is being acknowledged in the same cycle; otherwise it flags overflow.
module layer_controller_cfg_handshake
    import layer_controller_cfg_pio_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic commit_req,
    input  logic ack,
    input  logic overflow_clr,
    output logic commit_accept,
    output logic out_valid,
    output logic overflow
);

    hs_state_e state;
    hs_state_e state_next;
    logic      overflow_next;

    // State and overflow registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state    <= HS_IDLE;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            overflow <= overflow_next;
        end
    end

    // Next-state and overflow update
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_next    = state;
        overflow_next = overflow;
        if (overflow_clr) begin
            overflow_next = 1'b0;
        end
        case (state)
            HS_IDLE: begin
                if (commit_req) begin
                    state_next = HS_PENDING;
                end
            end
            HS_PENDING: begin
                if (ack && !commit_req) begin
                    state_next = HS_IDLE;
                end else if (commit_req && !ack) begin
                    // Assigned after the clear above, so a rejected commit wins
                    overflow_next = 1'b1;
                end
            end
            default: state_next = HS_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        out_valid     = (state == HS_PENDING);
        commit_accept = commit_req && ((state == HS_IDLE) || ack);
    end

endmodule

// File: rtl/layer_controller_cfg_pio.sv
// Layer controller configuration PIO: per-channel shadow registers written
// from the bus, copied atomically into the live outputs on an accepted commit.
module layer_controller_cfg_pio
    import layer_controller_cfg_pio_pkg::*;
#(
    parameter int                N_CH      = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
)(
    input  logic                       clk,
    input  logic                       reset,
    layer_controller_cfg_pio_if.slave  bus,
    output logic [N_CH*DATA_W-1:0]     out_port,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic                       irq
);

    localparam int ADDR_W = addr_w(N_CH);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CTRL_ADDR);
    localparam logic [ADDR_W-1:0] A_COMMIT = ADDR_W'(COMMIT_ADDR);

    logic                   wr_en;
    logic                   ctrl_wr;
    logic                   commit_req;
    logic                   overflow_clr;
    logic                   commit_accept;
    logic                   overflow;
    logic                   irq_en;
    logic [N_CH*DATA_W-1:0] shadow_flat;
    logic [31:0]            rdata;
    logic                   unused_wdata;

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign ctrl_wr      = wr_en && (bus.address == A_CTRL);
    assign commit_req   = wr_en && (bus.address == A_COMMIT) && bus.writedata[COMMIT_GO];
    assign overflow_clr = ctrl_wr && bus.writedata[STAT_OVERFLOW];
    assign unused_wdata = ^bus.writedata;

    layer_controller_cfg_handshake u_handshake (
        .clk           (clk),
        .reset         (reset),
        .commit_req    (commit_req),
        .ack           (out_ack),
        .overflow_clr  (overflow_clr),
        .commit_accept (commit_accept),
        .out_valid     (out_valid),
        .overflow      (overflow)
    );

    // Interrupt enable bit of CTRL
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            irq_en <= bus.writedata[STAT_IRQ_EN];
        end
    end

    assign irq = overflow && irq_en;

    // Per-channel shadow and live registers
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [ADDR_W-1:0] A_SHADOW = ADDR_W'(SHADOW_BASE + i);

        logic [DATA_W-1:0] shadow_q;
        logic [DATA_W-1:0] live_q;

        // Shadow takes the low DATA_W bits of a write to its own word;
        // live copies the shadow only when the handshake accepts a commit
        always_ff @(posedge clk) begin
            // NOTE: these registers are reset because RESET_VAL is the
            // defined power-up value driven to the layer, not just a default.
            if (reset) begin
                shadow_q <= RESET_VAL;
                live_q   <= RESET_VAL;
            end else begin
                if (wr_en && (bus.address == A_SHADOW)) begin
                    shadow_q <= bus.writedata[DATA_W-1:0];
                end
                if (commit_accept) begin
                    live_q <= shadow_q;
                end
            end
        end

        assign shadow_flat[i*DATA_W +: DATA_W] = shadow_q;
        assign out_port[i*DATA_W +: DATA_W]    = live_q;
    end

    // Read mux: combinational from address alone; COMMIT and unmapped read 0
    always_comb begin
        rdata = '0;
        if (bus.address == A_CTRL) begin
            rdata[STAT_PENDING]  = out_valid;
            rdata[STAT_OVERFLOW] = overflow;
            rdata[STAT_IRQ_EN]   = irq_en;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (bus.address == ADDR_W'(SHADOW_BASE + i)) begin
                rdata = 32'(shadow_flat[i*DATA_W +: DATA_W]);
            end
        end
    end

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_layer_controller_cfg_pio.sv
// Self-checking bench: a table of bus operations with expected results, a
// scoreboard queue for post-edge outputs, and hand-written reset sequences.
module tb_layer_controller_cfg_pio;
    import layer_controller_cfg_pio_pkg::*;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_CH*DATA_W-1:0] out_port;
    logic                   out_valid;
    logic                   out_ack;
    logic                   irq;

    layer_controller_cfg_pio_if #(.N_CH(N_CH)) bus ();

    layer_controller_cfg_pio #(
        .N_CH      (N_CH),
        .DATA_W    (DATA_W),
        .RESET_VAL ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef enum {OP_RD, OP_WR, OP_NOP} op_e;

    typedef struct {
        string       name;
        op_e         op;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] exp_rd;
        logic [31:0] exp_port;
        logic        exp_valid;
        logic        exp_irq;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] port;
        logic        valid;
        logic        irq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add_rd(input string name, input logic [2:0] addr, input logic [31:0] exp_rd,
                          input logic [31:0] port, input logic valid, input logic irq_e);
        vec_t v;
        v.name = name; v.op = OP_RD; v.addr = addr; v.wdata = '0; v.ack = 1'b0;
        v.exp_rd = exp_rd; v.exp_port = port; v.exp_valid = valid; v.exp_irq = irq_e;
        vecs.push_back(v);
    endtask

    task automatic add_op(input string name, input op_e op, input logic [2:0] addr,
                          input logic [31:0] wdata, input logic ack,
                          input logic [31:0] port, input logic valid, input logic irq_e);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.ack = ack;
        v.exp_rd = '0; v.exp_port = port; v.exp_valid = valid; v.exp_irq = irq_e;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input string name, input logic [31:0] port, input logic valid,
                            input logic irq_e);
        exp_t e;
        e.name = name; e.port = port; e.valid = valid; e.irq = irq_e;
        sb.push_back(e);
    endtask

    // One clock cycle with optional write and ack; inputs released #1 after the edge
    task automatic bus_cycle(input logic [2:0] addr, input logic [31:0] wdata,
                             input logic is_write, input logic ack);
        bus.address    = addr;
        bus.writedata  = wdata;
        bus.chipselect = is_write;
        bus.write_n    = !is_write;
        out_ack        = ack;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        out_ack        = 1'b0;
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.name, ".out_port"}, out_port, e.port);
            check({e.name, ".out_valid"}, 32'(out_valid), 32'(e.valid));
            check({e.name, ".irq"}, 32'(irq), 32'(e.irq));
        end
    endtask

    task automatic read_check(input string name, input logic [2:0] addr, input logic [31:0] exp);
        bus.address    = addr;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        #1;
        check(name, bus.readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        out_ack        = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: every address reads 0
        for (int a = 0; a < 8; a++) begin
            add_rd($sformatf("reset_rd%0d", a), 3'(a), 32'h0, 32'h0, 1'b0, 1'b0);
        end
        // Shadow writes do not reach out_port; upper bits dropped
        add_op("wr_sh0", OP_WR, 3'd2, 32'h11,  1'b0, 32'h0, 1'b0, 1'b0);
        add_op("wr_sh1", OP_WR, 3'd3, 32'h22,  1'b0, 32'h0, 1'b0, 1'b0);
        add_op("wr_sh2", OP_WR, 3'd4, 32'h33,  1'b0, 32'h0, 1'b0, 1'b0);
        add_op("wr_sh3", OP_WR, 3'd5, 32'h1FF, 1'b0, 32'h0, 1'b0, 1'b0);
        add_rd("rd_sh3", 3'd5, 32'hFF, 32'h0, 1'b0, 1'b0);
        add_rd("rd_sh0", 3'd2, 32'h11, 32'h0, 1'b0, 1'b0);
        // COMMIT with bit0=0 does nothing
        add_op("commit0", OP_WR, 3'd1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        add_rd("rd_ctrl_idle", 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        // First commit from IDLE
        add_op("commit1", OP_WR, 3'd1, 32'h1, 1'b0, 32'hFF332211, 1'b1, 1'b0);
        add_rd("rd_ctrl_pend", 3'd0, 32'h1, 32'hFF332211, 1'b1, 1'b0);
        add_rd("rd_commit", 3'd1, 32'h0, 32'hFF332211, 1'b1, 1'b0);
        // Rejected commit while PENDING sets overflow
        add_op("commit_rej", OP_WR, 3'd1, 32'h1, 1'b0, 32'hFF332211, 1'b1, 1'b0);
        add_rd("rd_ctrl_ovf", 3'd0, 32'h3, 32'hFF332211, 1'b1, 1'b0);
        add_op("irq_en", OP_WR, 3'd0, 32'h100, 1'b0, 32'hFF332211, 1'b1, 1'b1);
        add_rd("rd_ctrl_irq", 3'd0, 32'h103, 32'hFF332211, 1'b1, 1'b1);
        add_op("ovf_clr", OP_WR, 3'd0, 32'h102, 1'b0, 32'hFF332211, 1'b1, 1'b0);
        add_rd("rd_ctrl_clr", 3'd0, 32'h101, 32'hFF332211, 1'b1, 1'b0);
        // Commit in the same cycle as ack is accepted
        add_op("wr_sh0_b", OP_WR, 3'd2, 32'hAA, 1'b0, 32'hFF332211, 1'b1, 1'b0);
        add_op("commit_ack", OP_WR, 3'd1, 32'h1, 1'b1, 32'hFF3322AA, 1'b1, 1'b0);
        add_rd("rd_ctrl_ca", 3'd0, 32'h101, 32'hFF3322AA, 1'b1, 1'b0);
        add_op("ack_only", OP_NOP, 3'd0, 32'h0, 1'b1, 32'hFF3322AA, 1'b0, 1'b0);
        add_rd("rd_ctrl_ack", 3'd0, 32'h100, 32'hFF3322AA, 1'b0, 1'b0);
        add_op("ack_idle", OP_NOP, 3'd0, 32'h0, 1'b1, 32'hFF3322AA, 1'b0, 1'b0);
        add_op("commit_even", OP_WR, 3'd1, 32'hFFFFFFFE, 1'b0, 32'hFF3322AA, 1'b0, 1'b0);
        add_op("commit_idle_ack", OP_WR, 3'd1, 32'h1, 1'b1, 32'hFF3322AA, 1'b1, 1'b0);
        add_op("ack_only2", OP_NOP, 3'd0, 32'h0, 1'b1, 32'hFF3322AA, 1'b0, 1'b0);
        add_op("irq_dis", OP_WR, 3'd0, 32'h0, 1'b0, 32'hFF3322AA, 1'b0, 1'b0);
        add_rd("rd_ctrl_off", 3'd0, 32'h0, 32'hFF3322AA, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            push_exp(vecs[k].name, vecs[k].exp_port, vecs[k].exp_valid, vecs[k].exp_irq);
            if (vecs[k].op == OP_RD) begin
                read_check({vecs[k].name, ".readdata"}, vecs[k].addr, vecs[k].exp_rd);
            end else begin
                bus_cycle(vecs[k].addr, vecs[k].wdata, vecs[k].op == OP_WR, vecs[k].ack);
            end
            compare_outputs();
        end

        // Reset while PENDING with overflow and irq active
        push_exp("seq_sh1", 32'hFF3322AA, 1'b0, 1'b0);
        bus_cycle(3'd3, 32'h55, 1'b1, 1'b0);
        compare_outputs();
        push_exp("seq_commit", 32'hFF3355AA, 1'b1, 1'b0);
        bus_cycle(3'd1, 32'h1, 1'b1, 1'b0);
        compare_outputs();
        push_exp("seq_reject", 32'hFF3355AA, 1'b1, 1'b0);
        bus_cycle(3'd1, 32'h1, 1'b1, 1'b0);
        compare_outputs();
        push_exp("seq_irq", 32'hFF3355AA, 1'b1, 1'b1);
        bus_cycle(3'd0, 32'h100, 1'b1, 1'b0);
        compare_outputs();
        read_check("seq_ctrl_pre_reset", 3'd0, 32'h103);

        reset = 1'b1;
        push_exp("seq_reset", 32'h0, 1'b0, 1'b0);
        bus_cycle(3'd1, 32'h1, 1'b1, 1'b1);
        reset = 1'b0;
        compare_outputs();
        read_check("seq_ctrl_post_reset", 3'd0, 32'h0);
        read_check("seq_sh1_post_reset", 3'd3, 32'h0);

        // Unmapped writes are ignored
        push_exp("seq_wr_a7", 32'h0, 1'b0, 1'b0);
        bus_cycle(3'd7, 32'hFFFFFFFF, 1'b1, 1'b0);
        compare_outputs();
        push_exp("seq_wr_a6", 32'h0, 1'b0, 1'b0);
        bus_cycle(3'd6, 32'hFFFFFFFF, 1'b1, 1'b0);
        compare_outputs();
        for (int a = 0; a < 8; a++) begin
            read_check($sformatf("seq_unmapped_rd%0d", a), 3'(a), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
